// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_disp_pkg : 7-segment glyph constants and BCD glyph lookup. Rev 1.0
// ----------------------------------------------------------------------------
package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;

  // Segment bit positions within {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  // Non-decimal codes render as a dash so corrupt counter values are visible
  function automatic logic [7:0] bcd_glyph(input bcd_t bcd);
    case (bcd)
      4'd0:    bcd_glyph = SEG_0;
      4'd1:    bcd_glyph = SEG_1;
      4'd2:    bcd_glyph = SEG_2;
      4'd3:    bcd_glyph = SEG_3;
      4'd4:    bcd_glyph = SEG_4;
      4'd5:    bcd_glyph = SEG_5;
      4'd6:    bcd_glyph = SEG_6;
      4'd7:    bcd_glyph = SEG_7;
      4'd8:    bcd_glyph = SEG_8;
      4'd9:    bcd_glyph = SEG_9;
      default: bcd_glyph = SEG_DASH;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode : BCD + blank + dp to active-high {dp,g..a} segments. Rev 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // Blanking clears the glyph only; the decimal point stays visible
  always_comb begin
    seg         = blank ? SEG_OFF : bcd_glyph(bcd);
    seg[SEG_DP] = dp;
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_mux : time-multiplexed 7-segment scanner with frame-aligned commit.
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_scan_mux
  import bcd_disp_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit AN_ACT_LOW   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              update,
  input  logic              blank_lz,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_tick,
  output logic              pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [PW-1:0]     prescaler_q, prescaler_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_dig_q, shadow_dig_d, active_dig_q, active_dig_d;
  logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic              pending_q, pending_d, frame_tick_q, frame_tick_d;
  logic [7:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic              slot_end, wrap, drive, zero_above;
  logic [NDIG-1:0]   lz_mask;
  logic [3:0]        cur_digit;
  logic [7:0]        dec_seg;

  always_comb begin
    slot_end     = (prescaler_q == PRE_LAST);
    wrap         = slot_end && (idx_q == IDX_LAST);
    prescaler_d  = slot_end ? '0 : prescaler_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    active_dig_d = active_dig_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    frame_tick_d = wrap;

    // An update landing on the wrap edge bypasses the shadow so it is not lost
    if (wrap && update) begin
      shadow_dig_d = digits_in;
      shadow_dp_d  = dp_in;
      active_dig_d = digits_in;
      active_dp_d  = dp_in;
      pending_d    = 1'b0;
    end else begin
      if (wrap && pending_q) begin
        active_dig_d = shadow_dig_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
      if (update) begin
        shadow_dig_d = digits_in;
        shadow_dp_d  = dp_in;
        pending_d    = 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit  = 4'd0;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) cur_digit = active_dig_q[4*k +: 4];
    end
    // Digit k is a leading zero when it and every higher digit is zero
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_above = zero_above && (active_dig_q[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_above && (k != 0);
    end
  end

  seg7_decode u_decode (
    .bcd   (cur_digit),
    .blank (blank_lz && lz_mask[idx_q]),
    .dp    (active_dp_q[idx_q]),
    .seg   (dec_seg)
  );

  always_comb begin
    drive = (prescaler_q >= PRE_BLANK);
    an_d  = '0;
    seg_d = SEG_OFF;
    if (drive) begin
      an_d[idx_q] = 1'b1;
      seg_d       = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q ^ {8{SEG_ACT_LOW}};
  assign an         = an_q ^ {NDIG{AN_ACT_LOW}};
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg_scan_mux : directed checks of scan timing, commit, blanking, reset.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        update = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;   // rising edges since the last reset release

  seg_scan_mux #(
    .NDIG         (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .SEG_ACT_LOW  (1'b0),
    .AN_ACT_LOW   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .update     (update),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  // Outputs observed after edge n show slot s of frame f when n = 16f + 4s + 2..4
  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_an", 32'(an), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    rst = 1'b1;
    cyc = 0;

    step();
    check("rel1_an", 32'(an), 32'h0);
    check("rel1_seg", 32'(seg), 32'h00);
    step();
    check("rel2_an", 32'(an), 32'h1);
    check("rel2_seg", 32'(seg), 32'h3F);

    // Mid-frame update must wait for the wrap
    digits_in = 16'h1234;
    update    = 1'b1;
    step();
    update    = 1'b0;
    check("upd_pend", 32'(pending), 32'h1);
    goto(14);
    check("pre_s3_an", 32'(an), 32'h8);
    check("pre_s3_seg", 32'(seg), 32'h3F);
    check("pre_pend", 32'(pending), 32'h1);
    goto(15);
    check("pre_tick", 32'(frame_tick), 32'h0);
    goto(16);
    check("wrap_tick", 32'(frame_tick), 32'h1);
    check("wrap_pend", 32'(pending), 32'h0);
    check("wrap_seg_old", 32'(seg), 32'h3F);
    goto(17);
    check("f1_blank_an", 32'(an), 32'h0);
    check("f1_blank_seg", 32'(seg), 32'h00);
    check("f1_tick_off", 32'(frame_tick), 32'h0);
    goto(18);
    check("f1_s0_an", 32'(an), 32'h1);
    check("f1_s0_seg", 32'(seg), 32'h66);

    // Leading-zero blanking, loaded during frame 1
    goto(20);
    digits_in = 16'h0050;
    blank_lz  = 1'b1;
    update    = 1'b1;
    step();
    update    = 1'b0;
    goto(30);
    check("f1_s3_an", 32'(an), 32'h8);
    check("f1_s3_seg", 32'(seg), 32'h06);
    goto(34);
    check("lz_s0_seg", 32'(seg), 32'h3F);
    goto(38);
    check("lz_s1_an", 32'(an), 32'h2);
    check("lz_s1_seg", 32'(seg), 32'h6D);
    goto(42);
    check("lz_s2_an", 32'(an), 32'h4);
    check("lz_s2_seg", 32'(seg), 32'h00);
    goto(46);
    check("lz_s3_an", 32'(an), 32'h8);
    check("lz_s3_seg", 32'(seg), 32'h00);
    blank_lz = 1'b0;
    step();
    check("lz_off_seg", 32'(seg), 32'h3F);

    // Dash for non-BCD code, decimal point on digit 0
    goto(50);
    digits_in = 16'h00A0;
    dp_in     = 4'b0001;
    update    = 1'b1;
    step();
    update    = 1'b0;
    check("dash_pend", 32'(pending), 32'h1);
    goto(66);
    check("dp_s0_seg", 32'(seg), 32'hBF);
    goto(70);
    check("dash_s1_seg", 32'(seg), 32'h40);

    // Update landing exactly on the wrap edge (edge 80)
    goto(79);
    digits_in = 16'h9999;
    dp_in     = 4'b0000;
    update    = 1'b1;
    step();
    update    = 1'b0;
    check("cw_tick", 32'(frame_tick), 32'h1);
    check("cw_pend", 32'(pending), 32'h0);
    step();
    check("cw_pend2", 32'(pending), 32'h0);
    goto(82);
    check("cw_s0_seg", 32'(seg), 32'h6F);
    goto(90);
    check("cw_s2_an", 32'(an), 32'h4);
    check("cw_s2_seg", 32'(seg), 32'h6F);

    // Asynchronous reset mid slot-2 drive
    rst = 1'b0;
    #1;
    check("ar_an", 32'(an), 32'h0);
    check("ar_seg", 32'(seg), 32'h00);
    check("ar_pend", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    goto(2);
    check("ar_s0_an", 32'(an), 32'h1);
    check("ar_s0_seg", 32'(seg), 32'h3F);
    goto(15);
    check("ar_tick15", 32'(frame_tick), 32'h0);
    goto(16);
    check("ar_tick16", 32'(frame_tick), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
